// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multicycle FSM (master) and the datapath (slave)
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       zero;
    logic       memReady;
    logic       adrSrc;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic       memWrite;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resSrc;
    logic [1:0] aluOp;
    logic [1:0] immSrc;
    logic       retire;
    logic       illegal;
    logic [3:0] state;
    modport master (
        input  op, zero, memReady,
        output adrSrc, irWrite, pcWrite, regWrite, memWrite, aluSrcA, aluSrcB,
               resSrc, aluOp, immSrc, retire, illegal, state
    );
    modport slave (
        output op, zero, memReady,
        input  adrSrc, irWrite, pcWrite, regWrite, memWrite, aluSrcA, aluSrcB,
               resSrc, aluOp, immSrc, retire, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control FSM sequencing shared ALU, unified memory and register file
module multicycle_ctrl (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] TRAP     = 4'd15;
    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_SW  = 7'd35;
    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_I   = 7'd19;
    localparam logic [6:0] OP_BEQ = 7'd99;
    localparam logic [6:0] OP_JAL = 7'd111;
    logic [3:0] stateQ, stateD, decodeNext;
    logic       illegalQ, pcUpdate, branch, irW, regW, memW, ret;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= FETCH;
            illegalQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (stateQ == DECODE && stateD == TRAP) illegalQ <= 1'b1;
        end
    end
    always_comb decodeNext = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                             (bus.op == OP_R)   ? EXECUTER :
                             (bus.op == OP_I)   ? EXECUTEI :
                             (bus.op == OP_BEQ) ? BEQ :
                             (bus.op == OP_JAL) ? JAL : TRAP;
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            FETCH:              stateD = bus.memReady ? DECODE : FETCH;
            DECODE:             stateD = decodeNext;
            MEMADR:             stateD = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:            stateD = bus.memReady ? MEMWB : MEMREAD;
            MEMWRITE:           stateD = bus.memReady ? FETCH : MEMWRITE;
            MEMWB, ALUWB, BEQ:  stateD = FETCH;
            EXECUTER, EXECUTEI: stateD = ALUWB;
            JAL:                stateD = ALUWB;
            default:            stateD = TRAP;
        endcase
    end
    always_comb begin
        bus.adrSrc  = 1'b0;
        bus.aluSrcA = 2'b00;
        bus.aluSrcB = 2'b00;
        bus.resSrc  = 2'b00;
        bus.aluOp   = 2'b00;
        irW         = 1'b0;
        pcUpdate    = 1'b0;
        branch      = 1'b0;
        regW        = 1'b0;
        memW        = 1'b0;
        ret         = 1'b0;
        case (stateQ)
            FETCH: begin
                bus.aluSrcB = 2'b10;
                bus.resSrc  = 2'b10;
                irW         = bus.memReady;
                pcUpdate    = bus.memReady;
            end
            DECODE: begin
                bus.aluSrcA = 2'b01;
                bus.aluSrcB = 2'b01;
            end
            MEMADR: begin
                bus.aluSrcA = 2'b10;
                bus.aluSrcB = 2'b01;
            end
            MEMREAD: bus.adrSrc = 1'b1;
            MEMWB: begin
                bus.resSrc = 2'b01;
                regW       = 1'b1;
                ret        = 1'b1;
            end
            MEMWRITE: begin
                bus.adrSrc = 1'b1;
                memW       = 1'b1;
                ret        = bus.memReady;
            end
            EXECUTER: begin
                bus.aluSrcA = 2'b10;
                bus.aluOp   = 2'b10;
            end
            EXECUTEI: begin
                bus.aluSrcA = 2'b10;
                bus.aluSrcB = 2'b01;
                bus.aluOp   = 2'b10;
            end
            ALUWB: begin
                regW = 1'b1;
                ret  = 1'b1;
            end
            BEQ: begin
                bus.aluSrcA = 2'b10;
                bus.aluOp   = 2'b01;
                branch      = 1'b1;
                ret         = 1'b1;
            end
            JAL: begin
                bus.aluSrcA = 2'b01;
                bus.aluSrcB = 2'b10;
                pcUpdate    = 1'b1;
            end
            default: ;
        endcase
    end
    // enables are masked by rst_n so they drop the instant reset asserts, even mid-cycle
    assign bus.irWrite  = rst_n & irW;
    assign bus.pcWrite  = rst_n & (pcUpdate | (branch & bus.zero));
    assign bus.regWrite = rst_n & regW;
    assign bus.memWrite = rst_n & memW;
    assign bus.retire   = rst_n & ret;
    assign bus.immSrc   = (bus.op == OP_SW)  ? 2'b01 :
                          (bus.op == OP_BEQ) ? 2'b10 :
                          (bus.op == OP_JAL) ? 2'b11 : 2'b00;
    assign bus.illegal  = illegalQ;
    assign bus.state    = stateQ;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; per-cycle traces and cycles-per-instruction derived from the ISA timing rules
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [20:0] expQ[$];
    int cpiQ[$];
    int cnt = 0;
    int cpiWant;
    logic [20:0] expV;
    logic [6:0] ops [6] = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111};

    wire [20:0] actual = {bus.state, bus.adrSrc, bus.irWrite, bus.pcWrite, bus.regWrite,
                          bus.memWrite, bus.aluSrcA, bus.aluSrcB, bus.resSrc, bus.aluOp,
                          bus.immSrc, bus.retire, bus.illegal};

    function automatic logic [1:0] immOf(logic [6:0] o);
        return (o == 7'd35) ? 2'b01 : (o == 7'd99) ? 2'b10 : (o == 7'd111) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [20:0] ev(int st, int adr, int irw, int pcw, int rw, int mw,
                                       int a, int b, int r, int alu, int ret, int ill, logic [6:0] o);
        return {4'(st), 1'(adr), 1'(irw), 1'(pcw), 1'(rw), 1'(mw),
                2'(a), 2'(b), 2'(r), 2'(alu), immOf(o), 1'(ret), 1'(ill)};
    endfunction

    function automatic int rb();
        return int'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] badOp();
        logic [6:0] o;
        do o = 7'($urandom); while (o inside {7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111});
        return o;
    endfunction

    // monitor: per-cycle trace compare plus cycle count from fetch start to each retire
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expV = expQ.pop_front();
            checks++;
            if (actual !== expV) begin
                errors++;
                $display("FAIL trace @%0t: state got %0d required %0d, outputs got %h required %h",
                         $time, actual[20:17], expV[20:17], actual, expV);
            end
        end
        if (!rst_n) cnt = 0;
        else begin
            cnt++;
            if (bus.retire) begin
                checks++;
                if (cpiQ.size() == 0) begin
                    errors++;
                    $display("FAIL cpi @%0t: retire got 1 required 0 (no instruction pending)", $time);
                end else begin
                    cpiWant = cpiQ.pop_front();
                    if (cnt != cpiWant) begin
                        errors++;
                        $display("FAIL cpi @%0t: cycles got %0d required %0d", $time, cnt, cpiWant);
                    end
                end
                cnt = 0;
            end
        end
    end

    task automatic step(int r, logic [6:0] o, int z, int mr, logic [20:0] e);
        @(posedge clk);
        #1;
        rst_n = 1'(r);
        bus.op = o;
        bus.zero = 1'(z);
        bus.memReady = 1'(mr);
        expQ.push_back(e);
    endtask

    task automatic resetCycles(int n);
        logic [6:0] o;
        for (int k = 0; k < n; k++) begin
            o = 7'($urandom);
            step(0, o, rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, o));
        end
    endtask

    task automatic fetchDecode(logic [6:0] o, int fs);
        for (int k = 0; k < fs; k++) step(1, o, rb(), 0, ev(0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, o));
        step(1, o, rb(), 1, ev(0, 0, 1, 1, 0, 0, 0, 2, 2, 0, 0, 0, o));
        step(1, o, rb(), rb(), ev(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, o));
    endtask

    task automatic aluWb(logic [6:0] o);
        step(1, o, rb(), rb(), ev(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, o));
    endtask

    task automatic runInstr(logic [6:0] o, int z, int fs, int ms);
        int base;
        base = (o == 7'd3) ? 5 : (o == 7'd99) ? 3 : 4;
        cpiQ.push_back(base + fs + ((o == 7'd3 || o == 7'd35) ? ms : 0));
        fetchDecode(o, fs);
        if (o == 7'd3 || o == 7'd35) begin
            step(1, o, rb(), rb(), ev(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, o));
            if (o == 7'd3) begin
                for (int k = 0; k < ms; k++) step(1, o, rb(), 0, ev(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o));
                step(1, o, rb(), 1, ev(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o));
                step(1, o, rb(), rb(), ev(4, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, o));
            end else begin
                for (int k = 0; k < ms; k++) step(1, o, rb(), 0, ev(5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, o));
                step(1, o, rb(), 1, ev(5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, o));
            end
        end else if (o == 7'd51) begin
            step(1, o, rb(), rb(), ev(6, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0, 0, o));
            aluWb(o);
        end else if (o == 7'd19) begin
            step(1, o, rb(), rb(), ev(7, 0, 0, 0, 0, 0, 2, 1, 0, 2, 0, 0, o));
            aluWb(o);
        end else if (o == 7'd99) begin
            step(1, o, z, rb(), ev(9, 0, 0, z, 0, 0, 2, 0, 0, 1, 1, 0, o));
        end else begin
            step(1, o, rb(), rb(), ev(10, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0, o));
            aluWb(o);
        end
    endtask

    task automatic runTrap(logic [6:0] o, int n);
        fetchDecode(o, 0);
        for (int k = 0; k < n; k++) step(1, o, rb(), rb(), ev(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, o));
    endtask

    task automatic asyncReset();
        logic [20:0] e;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        e = ev(0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, bus.op);
        checks++;
        if (actual !== e) begin
            errors++;
            $display("FAIL async_reset @%0t: outputs got %h required %h", $time, actual, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.op = 7'd0;
        bus.zero = 1'b0;
        bus.memReady = 1'b1;
        resetCycles(2);
        runInstr(7'd51, 0, 0, 0);
        runInstr(7'd3, 0, 0, 2);
        runInstr(7'd35, 0, 0, 1);
        runInstr(7'd99, 1, 0, 0);
        runInstr(7'd99, 0, 0, 0);
        runInstr(7'd111, 0, 0, 0);
        runInstr(7'd19, 0, 1, 0);
        runTrap(7'h7F, 6);
        asyncReset();
        resetCycles(2);
        fetchDecode(7'd35, 0);
        step(1, 7'd35, rb(), rb(), ev(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 7'd35));
        for (int k = 0; k < 2; k++) step(1, 7'd35, rb(), 0, ev(5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7'd35));
        asyncReset();
        resetCycles(2);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                runTrap(badOp(), int'($urandom_range(1, 4)));
                asyncReset();
                resetCycles(int'($urandom_range(1, 2)));
            end else begin
                runInstr(ops[$urandom_range(0, 5)], rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0 || cpiQ.size() != 0) begin
            errors++;
            $display("FAIL drain: pending traces got %0d, pending retires got %0d, required 0 and 0",
                     expQ.size(), cpiQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences one shared ALU, one unified instruction/data memory port and the register file across several clock cycles per instruction. It decodes the opcode held in the instruction register and drives all datapath mux selects and write enables. It stalls on a memory-ready handshake and traps on unsupported opcodes.

## Interface
Parameters: none.

- clk  in  1  rising-edge clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode from instruction register (instr[6:0]); valid from DECODE onward.
- zero  in  1  ALU zero flag, same cycle.
- memReady  in  1  memory has completed the current access this cycle.
- adrSrc  out  1  memory address select: 0 = PC, 1 = result.
- irWrite  out  1  load instruction register and oldPC.
- pcWrite  out  1  PC load enable, equal to pcUpdate | (branch & zero).
- regWrite  out  1  register file write enable.
- memWrite  out  1  memory write strobe.
- aluSrcA  out  2  ALU A operand: 00 = PC, 01 = oldPC, 10 = rd1.
- aluSrcB  out  2  ALU B operand: 00 = rd2, 01 = immExt, 10 = constant 4.
- resSrc  out  2  result mux: 00 = aluOut register, 01 = read data, 10 = ALU result.
- aluOp  out  2  to ALU decoder: 00 = add, 01 = sub, 10 = use funct fields.
- immSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction.
- illegal  out  1  sticky trap flag.
- state  out  4  current state code, for debug and verification.

## Operation
- Supported opcodes: lw = 3, sw = 35, R-type = 51, I-ALU = 19, beq = 99, jal = 111.
- immSrc is combinational from op: 3 and 19 give 00, 35 gives 01, 99 gives 10, 111 gives 11, any other opcode gives 00.
- States and their codes:
  - FETCH = 0
  - DECODE = 1
  - MEMADR = 2
  - MEMREAD = 3
  - MEMWB = 4
  - MEMWRITE = 5
  - EXECUTER = 6
  - EXECUTEI = 7
  - ALUWB = 8
  - BEQ = 9
  - JAL = 10
  - TRAP = 15
- Per-state outputs. Any output not listed is 0; no x is ever driven.
  - FETCH: adrSrc = 0, aluSrcA = 00, aluSrcB = 10, aluOp = 00, resSrc = 10. irWrite = pcUpdate = memReady. Stays in FETCH while memReady = 0; goes to DECODE when memReady = 1.
  - DECODE: aluSrcA = 01, aluSrcB = 01, aluOp = 00, which precomputes the branch target into aluOut. Next state by op:
    - 3 or 35 → MEMADR
    - 51 → EXECUTER
    - 19 → EXECUTEI
    - 99 → BEQ
    - 111 → JAL
    - any other opcode → TRAP
  - MEMADR: aluSrcA = 10, aluSrcB = 01, aluOp = 00. Goes to MEMREAD if op = 3, otherwise MEMWRITE.
  - MEMREAD: adrSrc = 1, resSrc = 00. Holds until memReady = 1, then goes to MEMWB.
  - MEMWB: resSrc = 01, regWrite = 1, retire = 1. Goes to FETCH.
  - MEMWRITE: adrSrc = 1, resSrc = 00, memWrite = 1 for as long as the state is held. retire = memReady. Goes to FETCH when memReady = 1.
  - EXECUTER: aluSrcA = 10, aluSrcB = 00, aluOp = 10. Goes to ALUWB.
  - EXECUTEI: aluSrcA = 10, aluSrcB = 01, aluOp = 10. Goes to ALUWB.
  - ALUWB: resSrc = 00, regWrite = 1, retire = 1. Goes to FETCH.
  - BEQ: aluSrcA = 10, aluSrcB = 00, aluOp = 01, resSrc = 00, branch = 1 (internal). pcWrite = zero. retire = 1. Goes to FETCH.
  - JAL: aluSrcA = 01, aluSrcB = 10, aluOp = 00, resSrc = 00, pcUpdate = 1. The PC is loaded from aluOut, which holds the target. Goes to ALUWB, which writes oldPC + 4 to rd.
  - TRAP: all enables 0 and illegal = 1. Absorbing state; only reset leaves it.
- illegal is registered. It is set on the DECODE → TRAP transition and cleared only by reset.

## Timing
- The state register updates on the rising clk edge. All outputs except illegal are combinational from state, op, zero and memReady.
- Reset behaviour, effective immediately and asynchronously while rst_n = 0:
  - state = FETCH, illegal = 0.
  - irWrite, pcWrite, regWrite, memWrite and retire are forced to 0.
  - The muxes show their FETCH values.
- The first fetch completes at the first rising edge with rst_n = 1 and memReady = 1.
- Cycles per instruction with memReady held at 1:
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-type: 4
  - beq: 3
  - jal: 4
- Each cycle with memReady = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay constant while stalled.
- Reset asserted mid-instruction, including during a stalled MEMWRITE: memWrite drops immediately, and no further regWrite or pcWrite occurs.
- Exactly one retire pulse is produced per non-trapping instruction. A trapping opcode produces none.

## Test plan
- Reset with memReady = 1, then R-type (op = 51): states 0, 1, 6, 8, 0. regWrite = 1 only in state 8. retire is pulsed once. Total 4 cycles.
- lw (op = 3) with memReady low for 2 cycles in MEMREAD: sequence 0, 1, 2, 3, 3, 3, 4, 0. adrSrc = 1 in state 3. resSrc = 01 with regWrite in state 4.
- sw (op = 35) with memReady = 0 for 1 cycle: memWrite high for 2 cycles in state 5. retire is high only in the second cycle. regWrite is never 1.
- beq (op = 99): with zero = 1, pcWrite = 1 in state 9. With zero = 0, pcWrite = 0. Both cases return to FETCH after 3 cycles. immSrc = 10.
- jal (op = 111): states 0, 1, 10, 8. pcWrite = 1 in state 10. resSrc = 00 and regWrite = 1 in state 8. immSrc = 11.
- Illegal opcode 7'h7F: DECODE → TRAP (state = 15). illegal rises on the next edge, all enables stay 0, and the block remains in TRAP indefinitely. Asserting rst_n low returns state = 0 and illegal = 0.
